// File: rtl/rf_pkg.sv
// Shared constants, types and helper functions for the multi-port register file.
package rf_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Helper functions operate on fixed maximum-width vectors; callers zero-pad.
    localparam int unsigned MAX_WR     = 2;
    localparam int unsigned MAX_ADDR_W = 8;
    localparam int unsigned MAX_DEPTH  = 2 ** MAX_ADDR_W;
    localparam int unsigned WR_IDX_W   = 1;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_sel_t;

    // Highest-index enabled write port whose address matches addr.
    function automatic wr_sel_t rf_wr_select(
        input logic [MAX_WR-1:0]            en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
        input logic [MAX_ADDR_W-1:0]        addr
    );
        wr_sel_t s;
        s.hit = 1'b0;
        s.idx = '0;
        for (int unsigned w = 0; w < MAX_WR; w++) begin
            if (en[w] && (addrs[w*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                s.hit = 1'b1;
                s.idx = w[WR_IDX_W-1:0];
            end
        end
        return s;
    endfunction

    // Number of set bits in a pending vector.
    function automatic logic [MAX_ADDR_W:0] rf_popcount(input logic [MAX_DEPTH-1:0] v);
        logic [MAX_ADDR_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            c = c + {{MAX_ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW-hazard stalls, with registered popcount.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned N_WR     = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     RF_clk,
    input  logic                     RF_rst,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [2**ADDR_W-1:0]     pending,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]      pending_nxt;
    logic [MAX_DEPTH-1:0]  pending_pad;
    logic [MAX_ADDR_W:0]   cnt_wide;

    // Writes clear, then issue sets: the newer producer wins on a same-address collision.
    always_comb begin
        pending_nxt = pending;
        for (int unsigned w = 0; w < N_WR; w++) begin
            if (wr_en[w]) begin
                pending_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (issue_en) begin
            pending_nxt[issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    // Count computed on the next-state vector so it updates together with the bits.
    always_comb begin
        pending_pad = '0;
        pending_pad[DEPTH-1:0] = pending_nxt;
        cnt_wide = rf_popcount(pending_pad);
    end

    // Pending vector and count registers.
    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_wide[ADDR_W:0];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional zero register, write bypass
// and pending-producer scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned N_WR     = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     RF_clk,
    input  logic                     RF_rst,
    input  logic [N_RD*ADDR_W-1:0]   RF_rd_addr,
    output logic [N_RD*DATA_W-1:0]   RF_rd_data,
    output logic [N_RD-1:0]          RF_rd_busy,
    input  logic [N_WR-1:0]          RF_wr_en,
    input  logic [N_WR*ADDR_W-1:0]   RF_wr_addr,
    input  logic [N_WR*DATA_W-1:0]   RF_wr_data,
    input  logic                     RF_issue_en,
    input  logic [ADDR_W-1:0]        RF_issue_addr,
    output logic [ADDR_W:0]          RF_pending_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]            mem [DEPTH];
    logic [DEPTH-1:0]             pending;
    logic [MAX_WR-1:0]            en_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0] waddr_pad;
    logic [DATA_W-1:0]            wd_pad [MAX_WR];

    // Zero-pad the write ports to the fixed widths used by rf_wr_select.
    always_comb begin
        en_pad    = '0;
        waddr_pad = '0;
        for (int unsigned w = 0; w < MAX_WR; w++) begin
            wd_pad[w] = '0;
            if (w < N_WR) begin
                en_pad[w] = RF_wr_en[w];
                waddr_pad[w*MAX_ADDR_W +: ADDR_W] = RF_wr_addr[w*ADDR_W +: ADDR_W];
                wd_pad[w] = RF_wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    // Storage update; ports applied in ascending order so the highest index wins.
    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < N_WR; w++) begin
                if (RF_wr_en[w] &&
                    !((ZERO_REG != 0) && (RF_wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
                    mem[RF_wr_addr[w*ADDR_W +: ADDR_W]] <= RF_wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .N_WR     (N_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .RF_clk      (RF_clk),
        .RF_rst      (RF_rst),
        .wr_en       (RF_wr_en),
        .wr_addr     (RF_wr_addr),
        .issue_en    (RF_issue_en),
        .issue_addr  (RF_issue_addr),
        .pending     (pending),
        .pending_cnt (RF_pending_cnt)
    );

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]     raddr;
        logic [MAX_ADDR_W-1:0] raddr_pad;
        wr_sel_t               sel;
        logic                  is_zero;
        logic [DATA_W-1:0]     data;
        logic                  busy;

        // Read mux: zero register, then same-cycle bypass, then stored value.
        always_comb begin
            raddr     = RF_rd_addr[k*ADDR_W +: ADDR_W];
            raddr_pad = '0;
            raddr_pad[ADDR_W-1:0] = raddr;
            sel     = rf_wr_select(en_pad, waddr_pad, raddr_pad);
            is_zero = (ZERO_REG != 0) && (raddr == '0);
            data    = mem[raddr];
            busy    = pending[raddr];
            if (is_zero) begin
                data = '0;
                busy = 1'b0;
            end else if ((BYPASS != 0) && sel.hit) begin
                data = wd_pad[sel.idx];
                busy = RF_issue_en && (RF_issue_addr == raddr);
            end
        end

        assign RF_rd_data[k*DATA_W +: DATA_W] = data;
        assign RF_rd_busy[k]                  = busy;
    end

endmodule
